stochastic_computing_sng: RTL and testbench
===========================================

STOCHASTIC_COMPUTING_SNG -- requirements
Module: stochastic_computing_sng

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the LFSR width and the value width; legal range 2..24.
REQ-002 The block SHALL have parameter SEED, default 1, a SIZE-bit nonzero LFSR seed.
REQ-003 The block SHALL have a port i_clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have a port i_rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have a port i_valid, input, 1 bit: stream request valid.
REQ-006 The block SHALL have a port o_ready, output, 1 bit: request accepted when i_valid && o_ready at a rising edge.
REQ-007 The block SHALL have a port i_value, input, SIZE bits: target probability numerator, sampled on accept.
REQ-008 The block SHALL have a port i_len, input, SIZE bits: stream length in bits, sampled on accept; 0 means 2^SIZE-1.
REQ-009 The block SHALL have a port i_stop, input, 1 bit: abort the current stream.
REQ-010 The block SHALL have a port i_rand, input, SIZE bits: LFSR o_val.
REQ-011 The block SHALL have ports o_lfsr_en (1 bit), o_lfsr_set (1 bit) and o_lfsr_setval (SIZE bits), outputs that drive LFSR i_en, i_set and i_setval.
REQ-012 The block SHALL have ports o_bit and o_bit_valid, outputs, 1 bit each: the stochastic bitstream and its qualifier.
REQ-013 The block SHALL have a port o_done, output, 1 bit: one-cycle end-of-stream pulse.
REQ-014 The block SHALL have a port o_ones, output, SIZE bits: the count of 1 bits emitted in the last stream.

Function
REQ-015 The FSM SHALL have the states IDLE, SEED, RUN and DONE.
REQ-016 The FSM SHALL follow these transitions:
- IDLE to SEED on accept.
- SEED to RUN unconditionally.
- RUN to DONE when the remaining count is 1 at the edge, or when i_stop=1.
- DONE to IDLE unconditionally.
REQ-017 o_ready SHALL be 1 only in IDLE; i_valid outside IDLE SHALL be ignored.
REQ-018 On accept, value_reg SHALL capture i_value and the remaining counter SHALL load i_len, or 2^SIZE-1 when i_len=0.
REQ-019 In SEED, o_lfsr_set=1, o_lfsr_en=1 and o_lfsr_setval=SEED.
REQ-020 In all other states o_lfsr_set SHALL be 0 and o_lfsr_setval SHALL be SEED.
REQ-021 o_lfsr_en SHALL be 1 in SEED and RUN only.
REQ-022 In RUN, o_bit_valid SHALL be 1 and o_bit SHALL be (value_reg != 0) && (i_rand <= value_reg), combinational from i_rand; elsewhere o_bit=0 and o_bit_valid=0.
REQ-023 Latency: accept at edge k; SEED during cycle k+1; the first valid bit in cycle k+2 with i_rand=SEED.
REQ-024 Exactly N valid bits SHALL be emitted per unaborted stream (N = effective length), in consecutive cycles.
REQ-025 The remaining counter SHALL decrement by 1 per RUN cycle and never wrap.
REQ-026 With i_stop=1 in a RUN cycle, that cycle's bit SHALL still be valid and counted, and the next state SHALL be DONE.
REQ-027 i_stop SHALL be ignored outside RUN.
REQ-028 o_done SHALL be 1 exactly in the DONE cycle.
REQ-029 o_ones SHALL be stable in DONE and SHALL hold until the next accept.
REQ-030 A full-period stream (len 0) with a correctly connected LFSR SHALL yield o_ones = i_value exactly.

Reset
REQ-031 While i_rst=0 at an edge, the state SHALL go to IDLE, the counter, value_reg and o_ones SHALL clear to 0, and o_ready SHALL read 1 after reset.
REQ-032 o_bit, o_bit_valid, o_done, o_lfsr_en and o_lfsr_set SHALL reset to 0; o_lfsr_setval SHALL read SEED.
REQ-033 Reset in any state, including mid-RUN, SHALL abandon the stream with no o_done pulse.

Configuration
REQ-034 With the macro STOCHASTIC_COMPUTING_SNG_ONES_COUNT_EN defined, a SIZE-bit ones counter SHALL clear on accept, increment on each RUN cycle with o_bit=1, and drive o_ones.
REQ-035 Without STOCHASTIC_COMPUTING_SNG_ONES_COUNT_EN, no counter SHALL be built, o_ones SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification (SIZE=4, SEED=1, LFSR instance wired to i_rand/o_lfsr_*, counting enabled unless stated)
REQ-036 The bench SHALL cover: value=8, len=0 -> 15 valid bits, o_done in the cycle after the last bit, o_ones=8.
REQ-037 The bench SHALL cover: value=0, len=0 -> 15 bits all 0, o_ones=0; value=15, len=0 -> 15 bits all 1, o_ones=15.
REQ-038 The bench SHALL cover: value=5, len=3 -> exactly 3 valid bits; first bit 1 (i_rand=1 <= 5); o_ready low for 5 cycles after accept.
REQ-039 The bench SHALL cover: value=15, len=0, i_stop in the 4th RUN cycle -> 4 valid bits, o_done next cycle, o_ones=4; a new request is accepted in the following cycle.
REQ-040 The bench SHALL cover: i_rst=0 in the 6th RUN cycle -> next cycle o_bit_valid=0, o_done never pulses, o_ones=0, o_ready=1.
REQ-041 The bench SHALL cover: macro undefined, value=8, len=0 -> bitstream identical to REQ-036, o_ones=0.

Source files
------------

// File: rtl/stochastic_computing_sng.sv
// Stochastic-computing bitstream generator: compares an external LFSR value against a captured
// numerator for a programmed number of cycles. Define STOCHASTIC_COMPUTING_SNG_ONES_COUNT_EN to build the ones counter.
module stochastic_computing_sng #(
  parameter int unsigned     SIZE = 8,
  parameter logic [SIZE-1:0] SEED = SIZE'(1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [SIZE-1:0] i_value,
  input  logic [SIZE-1:0] i_len,
  input  logic            i_stop,
  input  logic [SIZE-1:0] i_rand,
  output logic            o_lfsr_en,
  output logic            o_lfsr_set,
  output logic [SIZE-1:0] o_lfsr_setval,
  output logic            o_bit,
  output logic            o_bit_valid,
  output logic            o_done,
  output logic [SIZE-1:0] o_ones
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic [SIZE-1:0] cnt_q;
  logic [SIZE-1:0] value_q;
  logic            accept;
  logic            run;
  logic            bit_w;

  assign accept = i_valid && (state_q == ST_IDLE);
  assign run    = (state_q == ST_RUN);
  assign bit_w  = run && (value_q != '0) && (i_rand <= value_q);

`ifdef STOCHASTIC_COMPUTING_SNG_ONES_COUNT_EN
  logic [SIZE-1:0] ones_q;
  assign o_ones = ones_q;
`else
  assign o_ones = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      value_q <= '0;
`ifdef STOCHASTIC_COMPUTING_SNG_ONES_COUNT_EN
      ones_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_SEED;
            value_q <= i_value;
            // A zero length selects the full LFSR period.
            cnt_q   <= (i_len == '0) ? '1 : i_len;
`ifdef STOCHASTIC_COMPUTING_SNG_ONES_COUNT_EN
            ones_q  <= '0;
`endif
          end
        end
        ST_SEED: state_q <= ST_RUN;
        ST_RUN: begin
          cnt_q <= cnt_q - 1'b1;
`ifdef STOCHASTIC_COMPUTING_SNG_ONES_COUNT_EN
          if (bit_w) ones_q <= ones_q + 1'b1;
`endif
          if ((cnt_q == SIZE'(1)) || i_stop) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready       = (state_q == ST_IDLE);
    o_lfsr_set    = (state_q == ST_SEED);
    o_lfsr_en     = (state_q == ST_SEED) || run;
    o_lfsr_setval = SEED;
    o_bit_valid   = run;
    o_bit         = bit_w;
    o_done        = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_stochastic_computing_sng.sv
// Randomized and directed bench for stochastic_computing_sng with SIZE=4, SEED=1 and a
// maximal-length 4-bit LFSR modelled locally and wired to i_rand/o_lfsr_*.
module tb_stochastic_computing_sng;
  localparam int unsigned SIZE = 4;
  localparam logic [SIZE-1:0] SEED = 4'd1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid;
  logic            ready;
  logic [SIZE-1:0] value;
  logic [SIZE-1:0] len;
  logic            stop;
  logic [SIZE-1:0] lfsr = 4'd1;
  logic            lfsr_en;
  logic            lfsr_set;
  logic [SIZE-1:0] lfsr_setval;
  logic            bit_o;
  logic            bit_valid;
  logic            done;
  logic [SIZE-1:0] ones;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned seq[15];

  stochastic_computing_sng #(.SIZE(SIZE), .SEED(SEED)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .o_ready(ready),
    .i_value(value), .i_len(len), .i_stop(stop), .i_rand(lfsr),
    .o_lfsr_en(lfsr_en), .o_lfsr_set(lfsr_set), .o_lfsr_setval(lfsr_setval),
    .o_bit(bit_o), .o_bit_valid(bit_valid), .o_done(done), .o_ones(ones)
  );

  always #5 clk = ~clk;

  // x^4 + x^3 + 1 Fibonacci LFSR, period 15
  always @(posedge clk) begin
    if (lfsr_set) lfsr <= lfsr_setval;
    else if (lfsr_en) lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: LFSR visits 1..15 in this order starting from SEED.
  function automatic void build_seq();
    int unsigned s = 1;
    for (int i = 0; i < 15; i++) begin
      seq[i] = s;
      s = ((s * 2) % 16) + (((s / 8) + (s / 4)) % 2);
    end
  endfunction

  function automatic int unsigned exp_ones(input int unsigned n);
`ifdef STOCHASTIC_COMPUTING_SNG_ONES_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // stop_at / rst_at: 1-based RUN cycle to assert i_stop / i_rst=0 in, 0 = never.
  task automatic stream(input int unsigned v, input int unsigned l,
                        input int unsigned stop_at, input int unsigned rst_at);
    int unsigned n;
    int unsigned cnt1;
    int unsigned w;
    bit          exp_bit;
    bit          ended;
    n = (l == 0) ? 15 : l;
    cnt1 = 0;
    w = 0;
    while (!ready && w < 40) begin tick(); w++; end
    check("ready_before_accept", ready, 1);
    valid = 1'b1; value = v[SIZE-1:0]; len = l[SIZE-1:0];
    tick();
    valid = $urandom_range(0, 1); value = $urandom; len = $urandom;
    stop = $urandom_range(0, 1);
    check("seed_ready", ready, 0);
    check("seed_set", lfsr_set, 1);
    check("seed_en", lfsr_en, 1);
    check("seed_setval", lfsr_setval, SEED);
    check("seed_bit_valid", bit_valid, 0);
    ended = 0;
    for (int c = 0; c < 15 && !ended; c++) begin
      tick();
      valid = 1'b0;
      stop = (stop_at == c + 1);
      exp_bit = (v != 0) && (seq[c] <= v);
      if (exp_bit) cnt1++;
      check("run_bit_valid", bit_valid, 1);
      check("run_bit", bit_o, exp_bit);
      check("run_done", done, 0);
      check("run_ready", ready, 0);
      check("run_lfsr_en", lfsr_en, 1);
      check("run_lfsr_set", lfsr_set, 0);
      if (rst_at == c + 1) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        stop = 1'b0;
        check("rst_bit_valid", bit_valid, 0);
        check("rst_done", done, 0);
        check("rst_ones", ones, 0);
        check("rst_ready", ready, 1);
        for (int k = 0; k < 4; k++) begin
          tick();
          check("rst_no_done", done, 0);
        end
        return;
      end
      ended = (c + 1 == n) || (stop_at == c + 1);
    end
    tick();
    stop = 1'b0;
    check("done_pulse", done, 1);
    check("done_bit_valid", bit_valid, 0);
    check("done_ready", ready, 0);
    check("done_lfsr_en", lfsr_en, 0);
    check("done_ones", ones, exp_ones(cnt1));
    tick();
    check("idle_done", done, 0);
    check("idle_ready", ready, 1);
    check("idle_ones_hold", ones, exp_ones(cnt1));
  endtask

  initial begin
    build_seq();
    rst_n = 1'b0; valid = 1'b0; value = '0; len = '0; stop = 1'b0;
    tick(); tick();
    check("reset_ready", ready, 1);
    check("reset_bit_valid", bit_valid, 0);
    check("reset_bit", bit_o, 0);
    check("reset_done", done, 0);
    check("reset_lfsr_en", lfsr_en, 0);
    check("reset_lfsr_set", lfsr_set, 0);
    check("reset_setval", lfsr_setval, SEED);
    check("reset_ones", ones, 0);
    rst_n = 1'b1;
    stop = 1'b1;
    tick();
    check("idle_stop_ignored", ready, 1);
    stop = 1'b0;
    tick();

    stream(8, 0, 0, 0);
    stream(0, 0, 0, 0);
    stream(15, 0, 0, 0);
    stream(5, 3, 0, 0);
    stream(15, 0, 4, 0);
    stream(3, 2, 0, 0);
    stream(9, 0, 0, 6);
    stream(1, 1, 0, 0);
    for (int t = 0; t < 25; t++) begin
      int unsigned rv = $urandom_range(0, 15);
      int unsigned rl = $urandom_range(0, 15);
      int unsigned rs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      stream(rv, rl, rs, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
